m_issue_ctrl: RTL and testbench
===============================

Name: m_issue_ctrl

Overview:
- Issue/completion controller directly downstream of the matrix functional-unit status table (one row: busy, rd, rs1, rs2, rs3).
- Waits until the row's source matrix registers are ready, then issues a matrix multiply-accumulate (rd = rs1*rs2 + rs3) to the systolic matrix unit with a valid/ready handshake.
- Tracks execution until done, then produces a one-cycle writeback broadcast and a row-clear pulse back to the status table.

Parameters:
- NUM_MREGS, 16, number of architectural matrix registers.
- MREG_W, $clog2(NUM_MREGS), matrix register index width.
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- fust_busy  in  1  status row holds a valid instruction.
- fust_rd  in  MREG_W  destination matrix register.
- fust_rs1  in  MREG_W  source A.
- fust_rs2  in  MREG_W  source B.
- fust_rs3  in  MREG_W  accumulator C.
- mreg_rdy  in  NUM_MREGS  per-register operand-ready vector from the register status logic.
- flush  in  1  squash any in-flight instruction.
- mfu_valid  out  1  issue request to the matrix unit.
- mfu_ready  in  1  matrix unit accepts the request.
- mfu_rd, mfu_rs1, mfu_rs2, mfu_rs3  out  MREG_W each  latched operand indices.
- mfu_done  in  1  matrix unit finished (single-cycle pulse).
- wb_valid  out  1  writeback broadcast.
- wb_rd  out  MREG_W  register being written back.
- fust_clr  out  1  clear the status row (single-cycle pulse).
- busy  out  1  controller not IDLE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - All outputs 0; latched indices 0.
- States: IDLE, WAIT_OPS, ISSUE, EXEC, WB.
- IDLE:
  - If fust_busy=1, latch rd/rs1/rs2/rs3 into internal registers and go to WAIT_OPS.
  - Row fields are sampled only on this transition; later row changes are ignored until the next IDLE.
- WAIT_OPS:
  - When mreg_rdy[rs1] & mreg_rdy[rs2] & mreg_rdy[rs3] is all 1 (latched indices; repeated indices are legal), go to ISSUE on the next edge.
  - Minimum latency from fust_busy to mfu_valid is 2 cycles.
- ISSUE:
  - mfu_valid=1 and mfu_* are driven from the latches.
  - mfu_* are stable while mfu_valid=1 and mfu_ready=0; mfu_valid is never dropped before acceptance.
  - On mfu_valid & mfu_ready, go to EXEC.
- EXEC:
  - Wait for mfu_done, then go to WB.
  - mfu_done in any other state is ignored.
- WB (one cycle):
  - wb_valid=1, wb_rd=latched rd, fust_clr=1, then IDLE.
  - A row re-busied in the cycle after WB is accepted normally; back-to-back instruction spacing is 1 idle cycle.
- flush (priority over every transition):
  - In WAIT_OPS or ISSUE: return to IDLE next cycle and pulse fust_clr; no wb_valid.
  - In EXEC: go to a drained sub-condition; stay in EXEC until mfu_done, then IDLE with fust_clr=1 and wb_valid=0.
  - In IDLE or WB: no effect.
- busy = (state != IDLE).
- Outputs wb_valid, fust_clr and mfu_valid are registered (driven from state), so there are no combinational paths from mfu_ready or mfu_done to outputs.

Optional Feature:
- Macro: M_ISSUE_TIMEOUT_EN.
- With the macro defined:
  - Add output timeout_err (1 bit, reset 0) and an 8-bit (or $clog2(TIMEOUT+1)-bit) counter, cleared on entry to EXEC.
  - The counter increments each EXEC cycle. Reaching TIMEOUT without mfu_done sets timeout_err (sticky until RST), forces fust_clr=1 and returns to IDLE.
- Without the macro: no port, no counter; EXEC waits indefinitely.

Decomposition:
- Shared package: m_issue_state_t enum (3-bit), MREG_W-based matrix register index typedef, and a m_issue_req_t struct {rd, rs1, rs2, rs3} reused by the matrix unit interface.
- Natural sub-module: m_operand_chk, a combinational 3-way ready lookup over mreg_rdy; the rest stays flat.

Test Plan:
- Basic path:
  - Stimulus: reset, then row busy with rd=3, rs1=1, rs2=2, rs3=3, all ready, mfu_ready=1, mfu_done 4 cycles after issue.
  - Required: mfu_valid at cycle 2; wb_valid and fust_clr with wb_rd=3 one cycle after done; then IDLE.
- Operand stall:
  - Stimulus: mreg_rdy[2]=0 for 5 cycles, then 1.
  - Required: mfu_valid stays low throughout the stall and rises 1 cycle after ready.
- Backpressure:
  - Stimulus: mfu_ready=0 for 3 cycles in ISSUE.
  - Required: mfu_valid held and mfu_rs1/2/3 unchanged; EXEC entered on the cycle after ready=1.
- Flush:
  - Stimulus: flush in WAIT_OPS.
  - Required: IDLE next cycle, fust_clr=1, wb_valid never asserted.
  - Stimulus: flush in EXEC.
  - Required: no wb_valid; fust_clr only after mfu_done.
- Reset mid-EXEC:
  - Stimulus: assert RST asynchronously.
  - Required: all outputs 0 immediately (before the next edge); later mfu_done ignored.
- Timeout (M_ISSUE_TIMEOUT_EN, TIMEOUT=10):
  - Stimulus: mfu_done never arrives.
  - Required: timeout_err=1 after 10 EXEC cycles, fust_clr pulse, state IDLE; timeout_err stays 1.

Source files
------------

// File: rtl/m_issue_pkg.sv
// Shared types for the matrix issue controller: FSM state, register index and
// the request bundle handed to the systolic matrix unit.
package m_issue_pkg;
  localparam int M_NUM_MREGS = 16;
  localparam int M_MREG_W    = $clog2(M_NUM_MREGS);

  typedef logic [M_MREG_W-1:0] mreg_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OPS,
    S_ISSUE,
    S_EXEC,
    S_WB
  } m_issue_state_t;

  typedef struct packed {
    mreg_idx_t rd;
    mreg_idx_t rs1;
    mreg_idx_t rs2;
    mreg_idx_t rs3;
  } m_issue_req_t;
endpackage

// File: rtl/m_issue_ctrl_operand_chk.sv
// Combinational 3-way operand-ready lookup; repeated source indices are legal.
module m_operand_chk
  import m_issue_pkg::*;
#(
  parameter int NUM_MREGS = M_NUM_MREGS,
  parameter int MREG_W    = $clog2(NUM_MREGS)
) (
  input  logic [NUM_MREGS-1:0] mreg_rdy,
  input  logic [MREG_W-1:0]    rs1,
  input  logic [MREG_W-1:0]    rs2,
  input  logic [MREG_W-1:0]    rs3,
  output logic                 ops_rdy
);
  assign ops_rdy = mreg_rdy[rs1] & mreg_rdy[rs2] & mreg_rdy[rs3];
endmodule

// File: rtl/m_issue_ctrl.sv
// Matrix MAC issue/completion controller for one status-table row.
// Optional EXEC watchdog enabled by defining M_ISSUE_TIMEOUT_EN.
module m_issue_ctrl
  import m_issue_pkg::*;
#(
  parameter int NUM_MREGS = M_NUM_MREGS,
  parameter int MREG_W    = $clog2(NUM_MREGS)
`ifdef M_ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 255
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 fust_busy,
  input  logic [MREG_W-1:0]    fust_rd,
  input  logic [MREG_W-1:0]    fust_rs1,
  input  logic [MREG_W-1:0]    fust_rs2,
  input  logic [MREG_W-1:0]    fust_rs3,
  input  logic [NUM_MREGS-1:0] mreg_rdy,
  input  logic                 flush,
  output logic                 mfu_valid,
  input  logic                 mfu_ready,
  output logic [MREG_W-1:0]    mfu_rd,
  output logic [MREG_W-1:0]    mfu_rs1,
  output logic [MREG_W-1:0]    mfu_rs2,
  output logic [MREG_W-1:0]    mfu_rs3,
  input  logic                 mfu_done,
  output logic                 wb_valid,
  output logic [MREG_W-1:0]    wb_rd,
  output logic                 fust_clr,
`ifdef M_ISSUE_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 busy
);
  m_issue_state_t state, nxt;
  m_issue_req_t   req_q;
  logic           ops_rdy, accept, abort, tmo;
  logic           drain, drain_nxt, clr_q;

  m_operand_chk #(.NUM_MREGS(NUM_MREGS), .MREG_W(MREG_W)) u_chk (
    .mreg_rdy (mreg_rdy),
    .rs1      (req_q.rs1),
    .rs2      (req_q.rs2),
    .rs3      (req_q.rs3),
    .ops_rdy  (ops_rdy)
  );

`ifdef M_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tcnt;

  // Fires on the TIMEOUT-th EXEC cycle; a coincident done still wins.
  assign tmo = (state == S_EXEC) && !mfu_done && (tcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= (state == S_EXEC) ? tcnt + 1'b1 : '0;
      if (tmo) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    abort     = 1'b0;
    drain_nxt = drain;
    case (state)
      // clr_q blocks re-latching the row that is being cleared this cycle
      S_IDLE:
        if (fust_busy && !clr_q) begin
          nxt    = S_WAIT_OPS;
          accept = 1'b1;
        end
      S_WAIT_OPS:
        if (flush) begin
          nxt   = S_IDLE;
          abort = 1'b1;
        end else if (ops_rdy) nxt = S_ISSUE;
      S_ISSUE:
        if (flush) begin
          nxt   = S_IDLE;
          abort = 1'b1;
        end else if (mfu_ready) nxt = S_EXEC;
      S_EXEC: begin
        if (flush) drain_nxt = 1'b1;
        if (mfu_done) begin
          if (drain || flush) begin
            nxt   = S_IDLE;
            abort = 1'b1;
          end else nxt = S_WB;
        end else if (tmo) begin
          nxt   = S_IDLE;
          abort = 1'b1;
        end
      end
      S_WB:    nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (nxt != S_EXEC) drain_nxt = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      req_q <= '0;
      drain <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state <= nxt;
      drain <= drain_nxt;
      clr_q <= abort;
      if (accept) req_q <= '{rd: fust_rd, rs1: fust_rs1, rs2: fust_rs2, rs3: fust_rs3};
    end
  end

  assign mfu_valid = (state == S_ISSUE);
  assign mfu_rd    = req_q.rd;
  assign mfu_rs1   = req_q.rs1;
  assign mfu_rs2   = req_q.rs2;
  assign mfu_rs3   = req_q.rs3;
  assign wb_valid  = (state == S_WB);
  assign wb_rd     = req_q.rd;
  assign fust_clr  = (state == S_WB) | clr_q;
  assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_m_issue_ctrl.sv
// Directed bench for m_issue_ctrl; define M_ISSUE_TIMEOUT_EN to add the watchdog check.
module tb_m_issue_ctrl;
  localparam int NUM_MREGS = 16;
  localparam int MREG_W    = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 fust_busy, flush, mfu_ready, mfu_done;
  logic [MREG_W-1:0]    fust_rd, fust_rs1, fust_rs2, fust_rs3;
  logic [NUM_MREGS-1:0] mreg_rdy;
  logic                 mfu_valid, wb_valid, fust_clr, busy;
  logic [MREG_W-1:0]    mfu_rd, mfu_rs1, mfu_rs2, mfu_rs3, wb_rd;
`ifdef M_ISSUE_TIMEOUT_EN
  logic                 timeout_err;
`endif

  int tests = 0;
  int fails = 0;

  m_issue_ctrl #(
    .NUM_MREGS(NUM_MREGS), .MREG_W(MREG_W)
`ifdef M_ISSUE_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .fust_busy(fust_busy), .fust_rd(fust_rd), .fust_rs1(fust_rs1),
    .fust_rs2(fust_rs2), .fust_rs3(fust_rs3),
    .mreg_rdy(mreg_rdy), .flush(flush),
    .mfu_valid(mfu_valid), .mfu_ready(mfu_ready),
    .mfu_rd(mfu_rd), .mfu_rs1(mfu_rs1), .mfu_rs2(mfu_rs2), .mfu_rs3(mfu_rs3),
    .mfu_done(mfu_done), .wb_valid(wb_valid), .wb_rd(wb_rd), .fust_clr(fust_clr),
`ifdef M_ISSUE_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic row(input logic [3:0] rd, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c);
    fust_busy = 1'b1;
    fust_rd = rd; fust_rs1 = a; fust_rs2 = b; fust_rs3 = c;
  endtask

  initial begin
    RST = 1'b1; fust_busy = 0; flush = 0; mfu_ready = 0; mfu_done = 0;
    fust_rd = 0; fust_rs1 = 0; fust_rs2 = 0; fust_rs3 = 0;
    mreg_rdy = 16'hFFFF;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_mfu_valid", mfu_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fust_clr", fust_clr, 0);
    chk("rst_mfu_rd", mfu_rd, 0);
    tick(); RST = 1'b0; tick();

    // basic path: issue at cycle 2, done 4 cycles after issue
    row(3, 1, 2, 3); mfu_ready = 1;
    tick();
    chk("basic_wait_valid", mfu_valid, 0);
    chk("basic_wait_busy", busy, 1);
    row(7, 7, 7, 7);
    tick();
    chk("basic_issue_valid", mfu_valid, 1);
    chk("basic_issue_ops", {mfu_rd, mfu_rs1, mfu_rs2, mfu_rs3}, 16'h3123);
    tick();
    chk("basic_exec_valid", mfu_valid, 0);
    tick(); tick(); tick();
    chk("basic_exec_no_wb", wb_valid, 0);
    mfu_done = 1;
    tick();
    mfu_done = 0;
    chk("basic_wb_valid", wb_valid, 1);
    chk("basic_wb_rd", wb_rd, 3);
    chk("basic_wb_clr", fust_clr, 1);
    fust_busy = 0;
    tick();
    chk("basic_idle_busy", busy, 0);
    chk("basic_idle_wb", wb_valid, 0);
    chk("basic_idle_clr", fust_clr, 0);

    // operand stall on reg 2, then backpressure in ISSUE
    row(5, 4, 2, 4); mreg_rdy[2] = 1'b0; mfu_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid_low", mfu_valid, 0);
      tick();
    end
    mreg_rdy[2] = 1'b1;
    chk("stall_still_low", mfu_valid, 0);
    tick();
    chk("stall_valid_rise", mfu_valid, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_valid_held", mfu_valid, 1);
      chk("bp_ops_stable", {mfu_rs1, mfu_rs2, mfu_rs3}, 12'h424);
    end
    mfu_ready = 1;
    tick();
    chk("bp_exec_valid", mfu_valid, 0);
    chk("bp_exec_busy", busy, 1);
    mfu_done = 1;
    tick();
    mfu_done = 0;
    chk("bp_wb_rd", wb_rd, 5);
    chk("bp_wb_valid", wb_valid, 1);
    fust_busy = 0;
    tick();

    // flush in WAIT_OPS; row stays busy during the clear cycle
    row(6, 0, 0, 0); mreg_rdy[0] = 1'b0;
    tick();
    chk("fw_wait_busy", busy, 1);
    flush = 1;
    tick();
    flush = 0;
    chk("fw_idle", busy, 0);
    chk("fw_clr", fust_clr, 1);
    chk("fw_no_wb", wb_valid, 0);
    tick();
    chk("fw_no_relatch", busy, 0);
    chk("fw_clr_pulse", fust_clr, 0);
    fust_busy = 0; mreg_rdy = 16'hFFFF;
    tick();

    // flush in EXEC: drain until done
    row(9, 1, 2, 3); mfu_ready = 1;
    tick(); tick(); tick();
    chk("fe_in_exec", {busy, mfu_valid}, 2'b10);
    flush = 1;
    tick();
    flush = 0;
    chk("fe_drain_busy", busy, 1);
    chk("fe_drain_clr", fust_clr, 0);
    tick();
    chk("fe_drain_wb", wb_valid, 0);
    chk("fe_drain_clr2", fust_clr, 0);
    mfu_done = 1;
    tick();
    mfu_done = 0;
    chk("fe_done_idle", busy, 0);
    chk("fe_done_clr", fust_clr, 1);
    chk("fe_done_no_wb", wb_valid, 0);
    fust_busy = 0;
    tick();
    chk("fe_clr_end", fust_clr, 0);

    // async reset mid-EXEC
    row(10, 1, 2, 3);
    tick(); tick(); tick();
    chk("rx_exec", busy, 1);
    chk("rx_latched_rd", mfu_rd, 10);
    #2 RST = 1'b1;
    #1;
    chk("rx_async_busy", busy, 0);
    chk("rx_async_rd", mfu_rd, 0);
    chk("rx_async_outs", {mfu_valid, wb_valid, fust_clr}, 0);
    fust_busy = 0;
    tick();
    RST = 1'b0; mfu_done = 1;
    tick();
    mfu_done = 0;
    chk("rx_done_ignored", {busy, wb_valid, fust_clr}, 0);

`ifdef M_ISSUE_TIMEOUT_EN
    // watchdog with TIMEOUT=10
    row(11, 1, 2, 3);
    tick(); tick(); tick();
    for (int i = 0; i < 9; i++) begin
      chk("to_exec_busy", busy, 1);
      chk("to_err_low", timeout_err, 0);
      tick();
    end
    chk("to_last_exec", busy, 1);
    tick();
    chk("to_err_set", timeout_err, 1);
    chk("to_clr", fust_clr, 1);
    chk("to_idle", busy, 0);
    chk("to_no_wb", wb_valid, 0);
    fust_busy = 0;
    tick();
    chk("to_err_sticky", timeout_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
